// File: rtl/alu_lockstep_seq_if.sv
// Lane-side bus between the lockstep self-test sequencer and the dual ALU pair.
// The sequencer drives identical operands/selects to both lanes and reads
// back the result XOR vector and the carry-compare bit.
interface alu_lockstep_seq_if;
  logic [3:0] a0_o;
  logic [3:0] b0_o;
  logic [3:0] a1_o;
  logic [3:0] b1_o;
  logic [1:0] sel1_o;
  logic [1:0] sel2_o;
  logic [3:0] x_i;
  logic       y_i;

  modport master (
    output a0_o, b0_o, a1_o, b1_o, sel1_o, sel2_o,
    input  x_i, y_i
  );

  modport slave (
    input  a0_o, b0_o, a1_o, b1_o, sel1_o, sel2_o,
    output x_i, y_i
  );
endinterface

// File: rtl/alu_lockstep_seq.sv
// Self-test sequencer and checker for the dual 4-bit ALU lockstep pair.
// An LFSR generates operand/select vectors that are issued to both lanes.
// After the ALU latency the comparator outputs are checked. Mismatches are
// counted, and the first failing vector is captured.
// Optional build macro FAULT_INJECT_EN adds inject_i/inject_idx_i. When the
// macro is set, bit 0 of lane 1's b operand is flipped at one chosen vector
// index, so the checker path can be demonstrated on a healthy ALU pair.
module alu_lockstep_seq #(
  parameter int          ALU_LAT   = 1,
  parameter int          VEC_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             stop_on_fail_i,
  input  logic [VEC_W-1:0] vec_count_i,
`ifdef FAULT_INJECT_EN
  input  logic             inject_i,
  input  logic [VEC_W-1:0] inject_idx_i,
`endif
  alu_lockstep_seq_if.master alu,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [7:0]       err_cnt_o,
  output logic [9:0]       fail_vec_o,
  output logic [VEC_W-1:0] fail_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE,
    S_HALT
  } state_t;

  localparam logic [2:0]       WAIT_LAST = 3'((ALU_LAT >= 2) ? (ALU_LAT - 2) : 0);
  localparam logic [VEC_W-1:0] IDX_ONE   = VEC_W'(1);

  state_t           state;
  state_t           next_state;
  logic             enter_done;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_next;
  logic [VEC_W-1:0] count_q;
  logic [VEC_W-1:0] index_q;
  logic [2:0]       wait_q;
  logic [3:0]       a_q;
  logic [3:0]       b_q;
  logic [3:0]       b1_q;
  logic [1:0]       sel_q;
  logic [7:0]       err_cnt_q;
  logic             fail_q;
  logic [9:0]       fail_vec_q;
  logic [VEC_W-1:0] fail_idx_q;
  logic             done_q;
  logic             mismatch;
  logic             last_vec;
  logic             inject_hit;

  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign mismatch  = (alu.x_i != 4'd0) | alu.y_i;
  assign last_vec  = (index_q == (count_q - IDX_ONE));

`ifdef FAULT_INJECT_EN
  logic             inject_q;
  logic [VEC_W-1:0] inject_idx_q;

  // Latch the injection request with the run parameters at start.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      inject_q     <= 1'b0;
      inject_idx_q <= '0;
    end else if (!abort_i && start_i &&
                 (state == S_IDLE || state == S_DONE || state == S_HALT)) begin
      inject_q     <= inject_i;
      inject_idx_q <= inject_idx_i;
    end
  end

  assign inject_hit = inject_q && (index_q == inject_idx_q);
`else
  assign inject_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic; abort overrides everything, start is only honoured when idle.
  always_comb begin
    next_state = state;
    enter_done = 1'b0;
    if (abort_i) begin
      next_state = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_HALT: begin
          if (start_i) begin
            if (vec_count_i == '0) begin
              next_state = S_DONE;
              enter_done = 1'b1;
            end else begin
              next_state = S_ISSUE;
            end
          end
        end
        S_ISSUE: next_state = (ALU_LAT == 1) ? S_CHECK : S_WAIT;
        S_WAIT:  if (wait_q == WAIT_LAST) next_state = S_CHECK;
        S_CHECK: begin
          if (mismatch && stop_on_fail_i) begin
            next_state = S_HALT;
          end else if (last_vec) begin
            next_state = S_DONE;
            enter_done = 1'b1;
          end else begin
            next_state = S_ISSUE;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Run datapath: vector generation, operand registers, latency counter and result capture.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lfsr_q     <= LFSR_SEED;
      count_q    <= '0;
      index_q    <= '0;
      wait_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      b1_q       <= '0;
      sel_q      <= '0;
      err_cnt_q  <= '0;
      fail_q     <= 1'b0;
      fail_vec_q <= '0;
      fail_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= enter_done;
      if (!abort_i) begin
        unique case (state)
          S_IDLE, S_DONE, S_HALT: begin
            if (start_i) begin
              count_q    <= vec_count_i;
              index_q    <= '0;
              lfsr_q     <= LFSR_SEED;
              err_cnt_q  <= '0;
              fail_q     <= 1'b0;
              fail_vec_q <= '0;
              fail_idx_q <= '0;
            end
          end
          S_ISSUE: begin
            sel_q  <= lfsr_q[9:8];
            a_q    <= lfsr_q[7:4];
            b_q    <= lfsr_q[3:0];
            b1_q   <= lfsr_q[3:0] ^ {3'b000, inject_hit};
            lfsr_q <= lfsr_next;
            wait_q <= '0;
          end
          S_WAIT: wait_q <= wait_q + 3'd1;
          S_CHECK: begin
            if (mismatch) begin
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              fail_q <= 1'b1;
              if (!fail_q) begin
                fail_vec_q <= {sel_q, a_q, b_q};
                fail_idx_q <= index_q;
              end
            end
            if (next_state == S_ISSUE) index_q <= index_q + IDX_ONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign alu.a0_o   = a_q;
  assign alu.a1_o   = a_q;
  assign alu.b0_o   = b_q;
  assign alu.b1_o   = b1_q;
  assign alu.sel1_o = sel_q;
  assign alu.sel2_o = sel_q;

  assign busy_o     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
  assign done_o     = done_q;
  assign fail_o     = fail_q;
  assign err_cnt_o  = err_cnt_q;
  assign fail_vec_o = fail_vec_q;
  assign fail_idx_o = fail_idx_q;

endmodule

// File: tb/tb_alu_lockstep_seq.sv
// Self-checking bench for alu_lockstep_seq (ALU_LAT=1, VEC_W=9 so that error
// saturation can be reached). A behavioural lane pair drives x/y; faults are
// planted by vector index. Expected vectors come from a plain-arithmetic LFSR model.
module tb_alu_lockstep_seq;
  localparam int VW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          stop_on_fail;
  logic [VW-1:0] vec_count;
  logic          busy;
  logic          done;
  logic          fail;
  logic [7:0]    err_cnt;
  logic [9:0]    fail_vec;
  logic [VW-1:0] fail_idx;

  int checks = 0;
  int fails  = 0;

  int fault_idx = -1;
  bit stuck_y   = 1'b0;
  int cyc       = 0;
  int busy_cnt  = 0;
  int done_cnt  = 0;
  bit done_prev = 1'b0;
  bit done_wide = 1'b0;

  logic [9:0] exp_vec [0:399];

  alu_lockstep_seq_if alu_bus ();

  alu_lockstep_seq #(.ALU_LAT(1), .VEC_W(VW), .LFSR_SEED(16'hACE1)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .start_i        (start),
    .abort_i        (abort),
    .stop_on_fail_i (stop_on_fail),
    .vec_count_i    (vec_count),
`ifdef FAULT_INJECT_EN
    .inject_i       (1'b0),
    .inject_idx_i   ('0),
`endif
    .alu            (alu_bus),
    .busy_o         (busy),
    .done_o         (done),
    .fail_o         (fail),
    .err_cnt_o      (err_cnt),
    .fail_vec_o     (fail_vec),
    .fail_idx_o     (fail_idx)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU lane: {carry, result}.
  function automatic logic [4:0] alu_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    case (sel)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  logic [4:0] lane1;
  logic [4:0] lane2;
  logic       force_x;
  assign lane1   = alu_op(alu_bus.a0_o, alu_bus.b0_o, alu_bus.sel1_o);
  assign lane2   = alu_op(alu_bus.a1_o, alu_bus.b1_o, alu_bus.sel2_o);
  assign force_x = busy && (fault_idx >= 0) && (cyc == 2 * fault_idx + 1);
  assign alu_bus.x_i = force_x ? 4'b0100 : (lane1[3:0] ^ lane2[3:0]);
  assign alu_bus.y_i = stuck_y | (lane1[4] ^ lane2[4]);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference vector sequence: 16-bit Fibonacci LFSR, taps 16,14,13,11, vector k is state after k steps.
  initial begin
    int s;
    s = 16'hACE1;
    for (int k = 0; k < 400; k++) begin
      exp_vec[k] = 10'(s % 1024);
      s = ((s * 2) % 65536) + (((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1);
    end
  end

  // Run monitor: counts busy cycles and done pulses, checks issued operands in each check cycle.
  always @(posedge clk) begin
    if (busy) begin
      if ((cyc % 2) == 1 && (cyc / 2) < 400) begin
        checkOutput("lane0_vec", {22'd0, alu_bus.sel1_o, alu_bus.a0_o, alu_bus.b0_o}, {22'd0, exp_vec[cyc / 2]});
        checkOutput("lane1_vec", {22'd0, alu_bus.sel2_o, alu_bus.a1_o, alu_bus.b1_o}, {22'd0, exp_vec[cyc / 2]});
      end
      busy_cnt++;
      cyc <= cyc + 1;
    end else begin
      cyc <= 0;
    end
    if (done) begin
      done_cnt++;
      if (done_prev) done_wide = 1'b1;
    end
    done_prev = done;
  end

  // Start one run and wait for it to finish, halt or abort; optional abort/restart at a busy-cycle count.
  task automatic applyStimulus(input int count, input bit stop, input int fidx, input bit sy,
                               input int abort_at, input int restart_at);
    bit finished;
    fault_idx    = fidx;
    stuck_y      = sy;
    stop_on_fail = stop;
    vec_count    = VW'(count);
    busy_cnt     = 0;
    done_cnt     = 0;
    done_wide    = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 2000 && !finished; i++) begin
      @(negedge clk);
      abort = (abort_at >= 0 && busy_cnt == abort_at);
      start = (restart_at >= 0 && busy_cnt == restart_at);
      if (!busy && (busy_cnt > 0 || done_cnt > 0)) finished = 1'b1;
    end
    abort = 1'b0;
    start = 1'b0;
    if (!finished) checkOutput("run_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int fi;
    bit st;
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    stop_on_fail = 1'b0;
    vec_count    = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_fail", {31'd0, fail}, 32'd0);
    checkOutput("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    checkOutput("rst_fail_vec", {22'd0, fail_vec}, 32'd0);
    checkOutput("rst_fail_idx", {23'd0, fail_idx}, 32'd0);
    checkOutput("rst_operands", {12'd0, alu_bus.sel1_o, alu_bus.a0_o, alu_bus.b0_o,
                                 alu_bus.sel2_o, alu_bus.a1_o, alu_bus.b1_o}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] healthy run of 16 vectors");
    applyStimulus(16, 1'b0, -1, 1'b0, -1, -1);
    checkOutput("healthy_busy_cycles", busy_cnt, 32);
    checkOutput("healthy_done_pulses", done_cnt, 1);
    checkOutput("healthy_done_wide", {31'd0, done_wide}, 32'd0);
    checkOutput("healthy_fail", {31'd0, fail}, 32'd0);
    checkOutput("healthy_err_cnt", {24'd0, err_cnt}, 32'd0);

    $display("[TB] x fault at vector 5, run to completion");
    applyStimulus(10, 1'b0, 5, 1'b0, -1, -1);
    checkOutput("x5_busy_cycles", busy_cnt, 20);
    checkOutput("x5_done_pulses", done_cnt, 1);
    checkOutput("x5_fail", {31'd0, fail}, 32'd1);
    checkOutput("x5_err_cnt", {24'd0, err_cnt}, 32'd1);
    checkOutput("x5_fail_idx", {23'd0, fail_idx}, 32'd5);
    checkOutput("x5_fail_vec", {22'd0, fail_vec}, {22'd0, exp_vec[5]});

    $display("[TB] x fault at vector 5, stop on fail");
    applyStimulus(10, 1'b1, 5, 1'b0, -1, -1);
    checkOutput("halt_busy_cycles", busy_cnt, 12);
    checkOutput("halt_done_pulses", done_cnt, 0);
    checkOutput("halt_busy", {31'd0, busy}, 32'd0);
    checkOutput("halt_err_cnt", {24'd0, err_cnt}, 32'd1);
    checkOutput("halt_fail_idx", {23'd0, fail_idx}, 32'd5);
    checkOutput("halt_operands", {22'd0, alu_bus.sel1_o, alu_bus.a0_o, alu_bus.b0_o}, {22'd0, exp_vec[5]});
    repeat (5) @(negedge clk);
    checkOutput("halt_operands_held", {22'd0, alu_bus.sel2_o, alu_bus.a1_o, alu_bus.b1_o}, {22'd0, exp_vec[5]});

    $display("[TB] zero-length run");
    applyStimulus(0, 1'b0, -1, 1'b0, -1, -1);
    checkOutput("zero_busy_cycles", busy_cnt, 0);
    checkOutput("zero_done_pulses", done_cnt, 1);
    checkOutput("zero_fail", {31'd0, fail}, 32'd0);
    checkOutput("zero_err_cnt", {24'd0, err_cnt}, 32'd0);
    checkOutput("zero_fail_vec", {22'd0, fail_vec}, 32'd0);

    $display("[TB] carry compare stuck, 300 vectors");
    applyStimulus(300, 1'b0, -1, 1'b1, -1, -1);
    checkOutput("sat_busy_cycles", busy_cnt, 600);
    checkOutput("sat_done_pulses", done_cnt, 1);
    checkOutput("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
    checkOutput("sat_fail_idx", {23'd0, fail_idx}, 32'd0);
    checkOutput("sat_fail_vec", {22'd0, fail_vec}, {22'd0, exp_vec[0]});

    $display("[TB] abort in issue of vector 3");
    applyStimulus(20, 1'b0, -1, 1'b1, 6, -1);
    checkOutput("abort_busy_cycles", busy_cnt, 7);
    checkOutput("abort_done_pulses", done_cnt, 0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_err_cnt", {24'd0, err_cnt}, 32'd3);
    checkOutput("abort_fail", {31'd0, fail}, 32'd1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      cnt = int'($urandom_range(1, 40));
      fi  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, cnt - 1));
      st  = 1'($urandom_range(0, 1));
      applyStimulus(cnt, st, fi, 1'b0, -1, 3);
      if (fi < 0) begin
        checkOutput("rnd_busy_cycles", busy_cnt, 2 * cnt);
        checkOutput("rnd_done_pulses", done_cnt, 1);
        checkOutput("rnd_err_cnt", {24'd0, err_cnt}, 32'd0);
      end else begin
        checkOutput("rnd_busy_cycles", busy_cnt, st ? 2 * (fi + 1) : 2 * cnt);
        checkOutput("rnd_done_pulses", done_cnt, st ? 0 : 1);
        checkOutput("rnd_err_cnt", {24'd0, err_cnt}, 32'd1);
        checkOutput("rnd_fail_idx", {23'd0, fail_idx}, fi);
        checkOutput("rnd_fail_vec", {22'd0, fail_vec}, {22'd0, exp_vec[fi]});
      end
    end

    $display("[TB] asynchronous reset mid-run");
    fault_idx = -1;
    stuck_y   = 1'b1;
    vec_count = VW'(20);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
    checkOutput("arst_fail", {31'd0, fail}, 32'd0);
    checkOutput("arst_operands", {22'd0, alu_bus.sel1_o, alu_bus.a0_o, alu_bus.b0_o}, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    stuck_y = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_lockstep_seq.md
Name: alu_lockstep_seq

Overview:
Self-test sequencer and checker for the dual 4-bit ALU lockstep pair (two lanes fed identical operands, result XOR vector x and carry-compare bit y). On start, generates pseudo-random operand/select vectors from an LFSR, drives both lanes, waits out the ALU pipeline latency, and samples the comparator outputs. Counts mismatches, captures the first failing vector, and reports status to the user-area wrapper via IO/LA.

Parameters:
ALU_LAT, 1, clock cycles from operand-register update to valid x/y (ALU is registered); legal 1..7
VEC_W, 8, width of vector-count input/index
LFSR_SEED, 16'hACE1, LFSR reset/start value; must be nonzero

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
start_i  in  1  begin run (level sampled; acted on only in IDLE/DONE/HALT)
abort_i  in  1  terminate run, return to IDLE
stop_on_fail_i  in  1  1: halt at first mismatch; 0: run to completion
vec_count_i  in  VEC_W  number of vectors per run, latched at start
x_i  in  4  ALU_Out1 XOR ALU_Out2
y_i  in  1  CarryOut1 XOR CarryOut2
a0_o, b0_o, a1_o, b1_o  out  4 each  lane operands
sel1_o, sel2_o  out  2 each  lane op selects
busy_o  out  1  run in progress (ISSUE/WAIT/CHECK)
done_o  out  1  one-cycle pulse at run completion
fail_o  out  1  sticky: any mismatch in current/last run
err_cnt_o  out  8  mismatch count, saturates at 255
fail_vec_o  out  10  first failing {sel[1:0], a[3:0], b[3:0]}
fail_idx_o  out  VEC_W  index of first failing vector

Behaviour:
- Reset: all outputs 0; LFSR = LFSR_SEED; state IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances once per ISSUE. Vector = {sel=lfsr[9:8], a=lfsr[7:4], b=lfsr[3:0]}; identical vector to both lanes (a0=a1, b0=b1, sel1=sel2).
- States: IDLE, ISSUE, WAIT, CHECK, DONE, HALT.
- IDLE/DONE/HALT + start_i: latch vec_count_i, clear err_cnt/fail/fail_vec/fail_idx, index=0, reload LFSR_SEED -> ISSUE. vec_count_i=0: go directly to DONE, pulse done_o next cycle, fail_o=0.
- ISSUE (1 cycle): operand registers load vector on exit edge -> WAIT.
- WAIT: ALU_LAT-1 cycles (0 cycles if ALU_LAT=1) -> CHECK. CHECK is the cycle where x_i/y_i correspond to the issued vector.
- CHECK (1 cycle): mismatch = (x_i!=0)|y_i. On mismatch: err_cnt+1 (saturating), fail_o=1; if first mismatch of run capture fail_vec/fail_idx. Then: mismatch & stop_on_fail_i -> HALT; else index==count-1 -> DONE; else index+1 -> ISSUE.
- Per-vector throughput: ALU_LAT+1 cycles.
- DONE: done_o pulses exactly one cycle on entry; outputs/status held.
- HALT: operands held at failing vector for debug; done_o not pulsed; start_i restarts.
- busy_o=1 in ISSUE/WAIT/CHECK only.
- start_i while busy: ignored. abort_i (any state, priority over start_i): -> IDLE next cycle, status held, no done_o.
- Async reset mid-run: immediate return to reset values.

Optional Feature:
FAULT_INJECT_EN: adds input inject_i (1b) and inject_idx_i (VEC_W). When defined and inject_i=1 at start, vector index inject_idx_i drives b1_o = b ^ 4'b0001 (lane 1 only) to prove checker path. Without macro: ports absent, lanes always identical.

Test Plan:
- Reset then start, vec_count=16, ALU_LAT=1, healthy ALU pair -> busy 32 cycles, done_o single pulse, fail_o=0, err_cnt=0.
- Force x_i=4'b0100 in CHECK of vector 5, stop_on_fail=0, count=10 -> run completes, err_cnt=1, fail_idx=5, fail_vec = LFSR vector 5.
- Same fault with stop_on_fail=1 -> HALT after vector 5, no done_o, operands frozen, busy_o=0.
- y_i=1 stuck, count=255+? (VEC_W=9 build, count=300) -> err_cnt saturates at 255, fail_idx=0.
- vec_count=0 -> DONE without ISSUE, done_o pulse, counters 0; abort_i during WAIT -> IDLE, no done_o.
- FAULT_INJECT_EN, inject_idx=3 with real alu pair -> b1_o differs in bit0 at vector 3 only, fail_idx=3 when op result differs.
